cache_ctrl: RTL and testbench

//  Direct-mapped, write-through, read-allocate cache controller; one-word lines.

---
 rtl/cache_pkg.sv | 49 ++++
 rtl/cache_valid_array.sv | 29 ++
 rtl/cache_ctrl.sv | 172 +++++++++++++++++
 tb/tb_cache_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped cache controller.
//   - geometry constants (index/tag/data/counter widths, address layout)
//   - FSM state encoding
//   - latched request record
//   - small helpers: word-aligned line address, saturating increment
package cache_pkg;

  localparam int INDEX_LENGTH = 4;
  localparam int TAG_LENGTH   = 22;
  localparam int DATA_WIDTH   = 32;
  localparam int CNT_WIDTH    = 16;

  localparam int CACHE_LINES  = 2 ** INDEX_LENGTH;
  localparam int ADDR_W       = TAG_LENGTH + INDEX_LENGTH + 2;

  // address = {tag, index, 2'b00}
  localparam int INDEX_LSB    = 2;
  localparam int TAG_LSB      = INDEX_LSB + INDEX_LENGTH;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_LOOKUP    = 3'd1;
  localparam state_t ST_REFILL    = 3'd2;
  localparam state_t ST_WRITE_MEM = 3'd3;
  localparam state_t ST_RESPOND   = 3'd4;

  typedef struct packed {
    logic                    we;
    logic [TAG_LENGTH-1:0]   tag;
    logic [INDEX_LENGTH-1:0] index;
    logic [DATA_WIDTH-1:0]   wdata;
  } req_t;

  function automatic logic [ADDR_W-1:0] line_addr(
    input logic [TAG_LENGTH-1:0]   tag,
    input logic [INDEX_LENGTH-1:0] index
  );
    return {tag, index, 2'b00};
  endfunction

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_ONE;
  endfunction

endpackage

// File: rtl/cache_valid_array.sv
// Per-line valid bits for the direct-mapped cache.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (clears all lines)
//   set_en     mark line set_idx valid on this edge
//   set_idx    line to mark valid
//   clr_all    invalidate every line on this edge (takes priority over set_en)
//   valid      current valid vector, one bit per line
module cache_valid_array
  import cache_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    set_en,
  input  logic [INDEX_LENGTH-1:0] set_idx,
  input  logic                    clr_all,
  output logic [CACHE_LINES-1:0]  valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (clr_all) begin
      valid <= '0;
    end else if (set_en) begin
      valid[set_idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, read-allocate cache controller, one-word lines.
// Drives the external tag/data RAMs, owns the valid bits and runs the CPU and
// memory handshakes. Hit/miss statistics saturate at all-ones.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cpu_req_i/we_i/addr_i/wdata_i   CPU request (sampled only in IDLE)
//   cpu_ready_o, cpu_rdata_o one-cycle completion pulse, load data
//   flush_i                  invalidate all lines (IDLE only, wins over a request)
//   tag_index_o/wtag_o/we_o, tag_rtag_i      tag RAM interface
//   data_we_o/wdata_o, data_rdata_i          data RAM interface
//   mem_req_o/we_o/addr_o/wdata_o, mem_ack_i/rdata_i   main memory handshake
//   hit_cnt_o, miss_cnt_o    saturating lookup statistics
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a request; flush handled here
// LOOKUP    | compare tag, count hit/miss, write data RAM on store hit
// REFILL    | load miss: read line from memory, allocate on ack
// WRITE_MEM | store: write word through to memory
// RESPOND   | one-cycle cpu_ready_o pulse
module cache_ctrl
  import cache_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    cpu_req_i,
  input  logic                    cpu_we_i,
  input  logic [ADDR_W-1:0]       cpu_addr_i,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata_i,
  output logic                    cpu_ready_o,
  output logic [DATA_WIDTH-1:0]   cpu_rdata_o,
  input  logic                    flush_i,

  output logic [INDEX_LENGTH-1:0] tag_index_o,
  output logic [TAG_LENGTH-1:0]   tag_wtag_o,
  output logic                    tag_we_o,
  input  logic [TAG_LENGTH-1:0]   tag_rtag_i,

  output logic                    data_we_o,
  output logic [DATA_WIDTH-1:0]   data_wdata_o,
  input  logic [DATA_WIDTH-1:0]   data_rdata_i,

  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_ack_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,

  output logic [CNT_WIDTH-1:0]    hit_cnt_o,
  output logic [CNT_WIDTH-1:0]    miss_cnt_o
);

  state_t                   state;
  state_t                   state_nxt;
  req_t                     req_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic [CNT_WIDTH-1:0]     hit_cnt_q;
  logic [CNT_WIDTH-1:0]     miss_cnt_q;
  logic [CACHE_LINES-1:0]   valid;

  logic                     accept;
  logic                     flush_now;
  logic                     hit;
  logic                     refill_ack;
  logic                     store_hit;
  logic                     addr_offset_unused;

  // Byte offset is architecturally ignored; the bus is word-aligned.
  assign addr_offset_unused = ^cpu_addr_i[INDEX_LSB-1:0];

  assign flush_now  = (state == ST_IDLE) && flush_i;
  assign accept     = (state == ST_IDLE) && !flush_i && cpu_req_i;
  assign hit        = valid[req_q.index] && (tag_rtag_i == req_q.tag);
  assign store_hit  = (state == ST_LOOKUP) && req_q.we && hit;
  assign refill_ack = (state == ST_REFILL) && mem_ack_i;

  cache_valid_array u_valid (
    .clk     (clk),
    .rst     (rst),
    .set_en  (refill_ack),
    .set_idx (req_q.index),
    .clr_all (flush_now),
    .valid   (valid)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (req_q.we)  state_nxt = ST_WRITE_MEM;
        else if (hit)  state_nxt = ST_RESPOND;
        else           state_nxt = ST_REFILL;
      end
      ST_REFILL: begin
        if (mem_ack_i) state_nxt = ST_RESPOND;
      end
      ST_WRITE_MEM: begin
        if (mem_ack_i) state_nxt = ST_RESPOND;
      end
      ST_RESPOND: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_q      <= '0;
      rdata_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        req_q.we    <= cpu_we_i;
        req_q.tag   <= cpu_addr_i[ADDR_W-1:TAG_LSB];
        req_q.index <= cpu_addr_i[TAG_LSB-1:INDEX_LSB];
        req_q.wdata <= cpu_wdata_i;
      end

      if (state == ST_LOOKUP) begin
        if (hit) begin
          hit_cnt_q <= sat_inc(hit_cnt_q);
        end else begin
          miss_cnt_q <= sat_inc(miss_cnt_q);
        end
        if (hit && !req_q.we) begin
          rdata_q <= data_rdata_i;
        end
      end

      if (refill_ack) begin
        rdata_q <= mem_rdata_i;
      end
    end
  end

  // RAM index and tag come from the latched request so they stay stable for
  // the whole transaction regardless of what the CPU drives afterwards.
  assign tag_index_o  = req_q.index;
  assign tag_wtag_o   = req_q.tag;
  assign tag_we_o     = refill_ack;

  // Store hits update the line in LOOKUP; refills write the fetched word.
  assign data_we_o    = store_hit || refill_ack;
  assign data_wdata_o = (state == ST_REFILL) ? mem_rdata_i : req_q.wdata;

  // Memory outputs are pure functions of state and latched request, so they
  // are stable while mem_req_o is high and drop as soon as the FSM leaves
  // (including on an asynchronous reset).
  assign mem_req_o    = (state == ST_REFILL) || (state == ST_WRITE_MEM);
  assign mem_we_o     = (state == ST_WRITE_MEM);
  assign mem_addr_o   = line_addr(req_q.tag, req_q.index);
  assign mem_wdata_o  = req_q.wdata;

  assign cpu_ready_o  = (state == ST_RESPOND);
  assign cpu_rdata_o  = rdata_q;

  assign hit_cnt_o    = hit_cnt_q;
  assign miss_cnt_o   = miss_cnt_q;

endmodule

// File: tb/tb_cache_ctrl.sv
module tb_cache_ctrl;
  import cache_pkg::*;

  logic                    clk;
  logic                    rst;
  logic                    cpu_req_i;
  logic                    cpu_we_i;
  logic [ADDR_W-1:0]       cpu_addr_i;
  logic [DATA_WIDTH-1:0]   cpu_wdata_i;
  logic                    cpu_ready_o;
  logic [DATA_WIDTH-1:0]   cpu_rdata_o;
  logic                    flush_i;
  logic [INDEX_LENGTH-1:0] tag_index_o;
  logic [TAG_LENGTH-1:0]   tag_wtag_o;
  logic                    tag_we_o;
  logic [TAG_LENGTH-1:0]   tag_rtag_i;
  logic                    data_we_o;
  logic [DATA_WIDTH-1:0]   data_wdata_o;
  logic [DATA_WIDTH-1:0]   data_rdata_i;
  logic                    mem_req_o;
  logic                    mem_we_o;
  logic [ADDR_W-1:0]       mem_addr_o;
  logic [DATA_WIDTH-1:0]   mem_wdata_o;
  logic                    mem_ack_i;
  logic [DATA_WIDTH-1:0]   mem_rdata_i;
  logic [CNT_WIDTH-1:0]    hit_cnt_o;
  logic [CNT_WIDTH-1:0]    miss_cnt_o;

  int total;
  int bad;

  // results of the most recent transaction
  int                  r_lat;
  logic [31:0]         r_rdata;
  logic                r_mem;
  logic [ADDR_W-1:0]   r_maddr;
  logic                r_mwe;
  logic [31:0]         r_mwdata;
  logic                r_unstable;
  logic                r_mreq_end;
  int                  r_tagwe;
  int                  r_datawe;
  int                  r_datawe_at;

  // tag/data RAMs that sit beside the controller
  logic [TAG_LENGTH-1:0] tag_ram  [CACHE_LINES];
  logic [DATA_WIDTH-1:0] data_ram [CACHE_LINES];

  assign tag_rtag_i   = tag_ram[tag_index_o];
  assign data_rdata_i = data_ram[tag_index_o];

  always @(posedge clk) begin
    if (tag_we_o)  tag_ram[tag_index_o]  <= tag_wtag_o;
    if (data_we_o) data_ram[tag_index_o] <= data_wdata_o;
  end

  cache_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req_i    (cpu_req_i),
    .cpu_we_i     (cpu_we_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .cpu_ready_o  (cpu_ready_o),
    .cpu_rdata_o  (cpu_rdata_o),
    .flush_i      (flush_i),
    .tag_index_o  (tag_index_o),
    .tag_wtag_o   (tag_wtag_o),
    .tag_we_o     (tag_we_o),
    .tag_rtag_i   (tag_rtag_i),
    .data_we_o    (data_we_o),
    .data_wdata_o (data_wdata_o),
    .data_rdata_i (data_rdata_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i),
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One CPU transaction. Latency counts negedges after the accept edge:
  // load hit = 2, miss/store = 2 + wait_cyc + 1.
  task automatic txn(input logic we, input logic [ADDR_W-1:0] addr,
                     input logic [31:0] wd, input int wait_cyc,
                     input logic [31:0] md, input logic with_flush);
    int  n;
    int  w;
    bit  done;
    n = 0; w = 0; done = 0;
    r_lat = 0; r_rdata = '0; r_mem = 0; r_maddr = '0; r_mwe = 0; r_mwdata = '0;
    r_unstable = 0; r_mreq_end = 0; r_tagwe = 0; r_datawe = 0; r_datawe_at = 0;
    @(negedge clk);
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wd;
    flush_i = with_flush;
    if (with_flush) begin
      @(posedge clk);
      @(negedge clk);
      flush_i = 1'b0;
    end
    @(posedge clk);
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      cpu_req_i = 1'b0;
      mem_ack_i = 1'b0;
      if (cpu_ready_o) begin
        done = 1; r_lat = n; r_rdata = cpu_rdata_o; r_mreq_end = mem_req_o;
      end else if (mem_req_o) begin
        if (!r_mem) begin
          r_mem = 1; r_maddr = mem_addr_o; r_mwe = mem_we_o; r_mwdata = mem_wdata_o;
        end else if (mem_addr_o !== r_maddr || mem_we_o !== r_mwe || mem_wdata_o !== r_mwdata) begin
          r_unstable = 1;
        end
        if (w == wait_cyc) begin
          mem_ack_i = 1'b1; mem_rdata_i = md;
        end
        w++;
      end
      #1;
      if (tag_we_o) r_tagwe++;
      if (data_we_o) begin
        r_datawe++; r_datawe_at = n;
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = '0; cpu_wdata_i = '0;
    flush_i = 0; mem_ack_i = 0; mem_rdata_i = '0;
    repeat (2) @(negedge clk);

    chk("rst_ready",  {31'd0, cpu_ready_o}, 0);
    chk("rst_rdata",  cpu_rdata_o, 0);
    chk("rst_mreq",   {31'd0, mem_req_o}, 0);
    chk("rst_maddr",  {4'd0, mem_addr_o}, 0);
    chk("rst_tagwe",  {31'd0, tag_we_o}, 0);
    chk("rst_datawe", {31'd0, data_we_o}, 0);
    chk("rst_hit",    {16'd0, hit_cnt_o}, 0);
    chk("rst_miss",   {16'd0, miss_cnt_o}, 0);
    rst = 1'b0;

    // cold load miss
    txn(0, 28'h40, 0, 2, 32'hDEADBEEF, 0);
    chk("m1_lat",    r_lat, 5);
    chk("m1_mem",    {31'd0, r_mem}, 1);
    chk("m1_maddr",  {4'd0, r_maddr}, 32'h40);
    chk("m1_mwe",    {31'd0, r_mwe}, 0);
    chk("m1_stable", {31'd0, r_unstable}, 0);
    chk("m1_tagwe",  r_tagwe, 1);
    chk("m1_datawe", r_datawe, 1);
    chk("m1_rdata",  r_rdata, 32'hDEADBEEF);
    chk("m1_mreqend",{31'd0, r_mreq_end}, 0);
    chk("m1_miss",   {16'd0, miss_cnt_o}, 1);
    chk("m1_hit",    {16'd0, hit_cnt_o}, 0);

    // load hit
    txn(0, 28'h40, 0, 0, 0, 0);
    chk("h1_lat",    r_lat, 2);
    chk("h1_mem",    {31'd0, r_mem}, 0);
    chk("h1_rdata",  r_rdata, 32'hDEADBEEF);
    chk("h1_datawe", r_datawe, 0);
    chk("h1_hit",    {16'd0, hit_cnt_o}, 1);

    // conflict miss, same index other tag
    txn(0, 28'h440, 0, 0, 32'hCAFE0001, 0);
    chk("c1_lat",    r_lat, 3);
    chk("c1_maddr",  {4'd0, r_maddr}, 32'h440);
    chk("c1_rdata",  r_rdata, 32'hCAFE0001);
    chk("c1_tagram", {10'd0, tag_ram[0]}, 32'h11);
    chk("c1_miss",   {16'd0, miss_cnt_o}, 2);

    // original line evicted
    txn(0, 28'h40, 0, 1, 32'hDEADBEEF, 0);
    chk("c2_lat",    r_lat, 4);
    chk("c2_mem",    {31'd0, r_mem}, 1);
    chk("c2_miss",   {16'd0, miss_cnt_o}, 3);

    // store hit: data RAM written in LOOKUP, write-through to memory
    txn(1, 28'h40, 32'h12345678, 1, 0, 0);
    chk("s1_lat",     r_lat, 4);
    chk("s1_datawe",  r_datawe, 1);
    chk("s1_dweat",   r_datawe_at, 1);
    chk("s1_tagwe",   r_tagwe, 0);
    chk("s1_mwe",     {31'd0, r_mwe}, 1);
    chk("s1_maddr",   {4'd0, r_maddr}, 32'h40);
    chk("s1_mwdata",  r_mwdata, 32'h12345678);
    chk("s1_dram",    data_ram[0], 32'h12345678);
    chk("s1_rdhold",  r_rdata, 32'hDEADBEEF);
    chk("s1_hit",     {16'd0, hit_cnt_o}, 2);

    txn(0, 28'h40, 0, 0, 0, 0);
    chk("h2_lat",    r_lat, 2);
    chk("h2_rdata",  r_rdata, 32'h12345678);

    // store miss: no allocate
    txn(1, 28'h80, 32'hAAAA5555, 0, 0, 0);
    chk("s2_lat",    r_lat, 3);
    chk("s2_datawe", r_datawe, 0);
    chk("s2_tagwe",  r_tagwe, 0);
    chk("s2_maddr",  {4'd0, r_maddr}, 32'h80);
    chk("s2_mwdata", r_mwdata, 32'hAAAA5555);
    chk("s2_dram",   data_ram[0], 32'h12345678);
    chk("s2_tagram", {10'd0, tag_ram[0]}, 32'h1);
    chk("s2_miss",   {16'd0, miss_cnt_o}, 4);

    txn(0, 28'h40, 0, 0, 0, 0);
    chk("h3_lat",    r_lat, 2);
    chk("h3_rdata",  r_rdata, 32'h12345678);
    chk("h3_hit",    {16'd0, hit_cnt_o}, 4);

    // flush together with a request: flush first, request one cycle later, misses
    txn(0, 28'h40, 0, 0, 32'h0BADF00D, 1);
    chk("f1_lat",    r_lat, 3);
    chk("f1_mem",    {31'd0, r_mem}, 1);
    chk("f1_rdata",  r_rdata, 32'h0BADF00D);
    chk("f1_miss",   {16'd0, miss_cnt_o}, 5);

    // reset while REFILL waits for memory
    @(negedge clk);
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 28'h44;
    @(posedge clk);
    @(negedge clk);
    cpu_req_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("r_pre_mreq", {31'd0, mem_req_o}, 1);
    chk("r_pre_miss", {16'd0, miss_cnt_o}, 6);
    #2 rst = 1'b1;
    #1;
    chk("r_mreq",  {31'd0, mem_req_o}, 0);
    chk("r_mwe",   {31'd0, mem_we_o}, 0);
    chk("r_maddr", {4'd0, mem_addr_o}, 0);
    chk("r_ready", {31'd0, cpu_ready_o}, 0);
    chk("r_rdata", cpu_rdata_o, 0);
    chk("r_hit",   {16'd0, hit_cnt_o}, 0);
    chk("r_miss",  {16'd0, miss_cnt_o}, 0);
    @(negedge clk);
    rst = 1'b0;

    txn(0, 28'h40, 0, 0, 32'h11112222, 0);
    chk("r_post_lat",  r_lat, 3);
    chk("r_post_mem",  {31'd0, r_mem}, 1);
    chk("r_post_miss", {16'd0, miss_cnt_o}, 1);

    // hit counter saturation
    @(negedge clk);
    force dut.hit_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.hit_cnt_q;
    chk("sat_pre", {16'd0, hit_cnt_o}, 32'hFFFE);
    txn(0, 28'h40, 0, 0, 0, 0);
    chk("sat_lat1", r_lat, 2);
    chk("sat_hit1", {16'd0, hit_cnt_o}, 32'hFFFF);
    txn(0, 28'h40, 0, 0, 0, 0);
    chk("sat_rdata", r_rdata, 32'h11112222);
    chk("sat_hit2",  {16'd0, hit_cnt_o}, 32'hFFFF);
    chk("sat_miss",  {16'd0, miss_cnt_o}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
